// File: rtl/char_tile_renderer_pkg.sv
// Shared text-mode geometry and the bundle of sync signals that travels
// alongside the rendered pixels.
package char_tile_renderer_pkg;

  localparam int TEXT_COLS      = 32;
  localparam int TEXT_ROWS      = 30;
  localparam int CELL_W         = 8;
  localparam int CELL_H         = 8;
  localparam int RENDER_LATENCY = 5;

  // Visible text area in pixels (256 x 240).
  localparam int VIS_W = TEXT_COLS * CELL_W;
  localparam int VIS_H = TEXT_ROWS * CELL_H;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
  } sync_bits_t;

endpackage

// File: rtl/sync_delay.sv
// Fixed-length shift-register delay line with synchronous clear; also
// exposes the stage just before the output for logic that registers it once more.
module sync_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_prev
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout      = stages[DEPTH-1];
  assign dout_prev = stages[DEPTH-2];

endmodule

// File: rtl/char_tile_renderer.sv
// Text-mode pixel stage: fetches 8x8 character cells through a sync char RAM
// and font ROM, serialises font rows to rgb, overlays a blinking block cursor.
module char_tile_renderer
  import char_tile_renderer_pkg::*;
#(
  parameter logic [2:0] FG_COLOR   = 3'b111,
  parameter logic [2:0] BG_COLOR   = 3'b000,
  parameter int         BLINK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic        display_on,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  ram_addr,
  input  logic [7:0]  ram_data,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        cursor_en,
  input  logic [4:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [2:0]  rgb,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        display_on_o
);

  sync_bits_t sync_q;
  sync_bits_t sync_tap;
  sync_bits_t sync_out;

  logic                  fetch_go;
  logic                  cursor_hit;
  logic                  blink_on;
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic [4:1]            valid_pipe;
  logic [4:1]            hit_pipe;
  logic [2:0]            line_s1;
  logic [2:0]            line_s2;
  logic [7:0]            shifter;

  assign fetch_go   = display_on && (hpos[2:0] == 3'd0) &&
                      (hpos < 9'(VIS_W)) && (vpos < 9'(VIS_H));
  assign cursor_hit = cursor_en && (hpos[7:3] == cursor_col) &&
                      (vpos[7:3] == cursor_row);
  assign blink_on   = frame_cnt[BLINK_LOG2-1];

  // The input sample register doubles as the previous-vsync flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      frame_cnt <= '0;
    end else begin
      sync_q <= '{hsync: hsync, vsync: vsync, display_on: display_on};
      if (vsync && !sync_q.vsync) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Cell fetch: RAM address at t, ROM address at t+2 once the char code arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr   <= '0;
      rom_addr   <= '0;
      valid_pipe <= '0;
      hit_pipe   <= '0;
      line_s1    <= '0;
      line_s2    <= '0;
    end else begin
      valid_pipe <= {valid_pipe[3:1], fetch_go};
      hit_pipe   <= {hit_pipe[3:1], cursor_hit};
      line_s1    <= vpos[2:0];
      line_s2    <= line_s1;
      if (fetch_go) begin
        ram_addr <= {vpos[7:3], hpos[7:3]};
      end
      if (valid_pipe[2]) begin
        rom_addr <= {ram_data, line_s2};
      end
    end
  end

  // A fresh font row replaces the eighth shift, so adjacent cells abut with no gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      shifter <= '0;
      rgb     <= '0;
    end else begin
      if (valid_pipe[4]) begin
        shifter <= (hit_pipe[4] && blink_on) ? ~rom_data : rom_data;
      end else begin
        shifter <= {shifter[6:0], 1'b0};
      end
      if (sync_tap.display_on) begin
        rgb <= shifter[7] ? FG_COLOR : BG_COLOR;
      end else begin
        rgb <= 3'b000;
      end
    end
  end

  sync_delay #(
    .WIDTH (3),
    .DEPTH (RENDER_LATENCY)
  ) u_sync_delay (
    .clk       (clk),
    .reset     (reset),
    .din       (sync_q),
    .dout      (sync_out),
    .dout_prev (sync_tap)
  );

  assign hsync_o      = sync_out.hsync;
  assign vsync_o      = sync_out.vsync;
  assign display_on_o = sync_out.display_on;

endmodule

// File: tb/tb_char_tile_renderer.sv
// Randomised bench for char_tile_renderer: behavioural RAM/ROM, a scan
// generator, and a reference model that recomputes every pixel from cell rules.
module tb_char_tile_renderer;

  localparam int FG = 7;
  localparam int BG = 0;

  logic        clk;
  logic        reset;
  logic [8:0]  hpos;
  logic [8:0]  vpos;
  logic        display_on;
  logic        hsync;
  logic        vsync;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_data;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        cursor_en;
  logic [4:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [2:0]  rgb;
  logic        hsync_o;
  logic        vsync_o;
  logic        display_on_o;

  typedef struct {
    int h;
    int v;
    bit disp;
    bit hs;
    bit vs;
    bit rst;
    bit cen;
    int ccol;
    int crow;
    int fc;
    int tag;
    int frame;
  } sample_t;

  sample_t    hist[$];
  logic [7:0] ram_mem [1024];
  logic [7:0] rom_mem [2048];

  int checks = 0;
  int fails = 0;
  int last_rst = -1000;
  int model_fc = 0;
  bit model_vs_q = 0;
  int exp_ram = 0;
  int exp_rom = 0;
  int cur_tag = 0;
  int cur_frame = 0;
  bit rand_cursor = 0;
  int t2_pat[8] = '{7, 0, 7, 0, 0, 7, 0, 7};

  char_tile_renderer dut (
    .clk          (clk),
    .reset        (reset),
    .hpos         (hpos),
    .vpos         (vpos),
    .display_on   (display_on),
    .hsync        (hsync),
    .vsync        (vsync),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .cursor_en    (cursor_en),
    .cursor_col   (cursor_col),
    .cursor_row   (cursor_row),
    .rgb          (rgb),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .display_on_o (display_on_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous char RAM and font ROM: data one cycle after the address.
  always @(posedge clk) begin
    ram_data <= ram_mem[ram_addr];
    rom_data <= rom_mem[rom_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic bit is_fetch(input sample_t s);
    return s.disp && (s.h % 8 == 0) && (s.h < 256) && (s.v < 240);
  endfunction

  function automatic int cell_index(input sample_t s);
    return (s.v / 8) * 32 + (s.h / 8);
  endfunction

  // Pixel for sample k, from the cell sampled at the start of its 8-pixel run.
  function automatic int exp_pixel(input int k);
    sample_t sk;
    sample_t st;
    int      t;
    int      row;
    bit      hit;
    sk = hist[k];
    if (!sk.disp) return 0;
    t = k - (sk.h % 8);
    if (t < 0 || last_rst >= t) return 0;
    st  = hist[t];
    row = int'(rom_mem[int'(ram_mem[cell_index(st)]) * 8 + st.v % 8]);
    hit = st.cen && (st.ccol == st.h / 8) && (st.crow == st.v / 8);
    if (hit && hist[t+3].fc >= 16) row = (~row) & 8'hFF;
    return ((row >> (7 - sk.h % 8)) & 1) != 0 ? FG : BG;
  endfunction

  // Advance the reference model over edge n and compare everything the DUT shows after it.
  task automatic model_step(input int n);
    sample_t s;
    sample_t sk;
    sample_t sr;
    int      k;
    int      e_rgb;
    bit      e_hs;
    bit      e_vs;
    bit      e_disp;
    s = hist[n];
    if (s.rst) begin
      last_rst   = n;
      model_fc   = 0;
      model_vs_q = 0;
      exp_ram    = 0;
      exp_rom    = 0;
    end else begin
      if (s.vs && !model_vs_q) model_fc = (model_fc + 1) % 32;
      model_vs_q = s.vs;
      if (is_fetch(s)) exp_ram = cell_index(s);
      if (n >= 2 && last_rst < n - 2 && is_fetch(hist[n-2])) begin
        sr      = hist[n-2];
        exp_rom = int'(ram_mem[cell_index(sr)]) * 8 + sr.v % 8;
      end
    end
    s.fc    = model_fc;
    hist[n] = s;

    k = n - 5;
    if (k < 0 || last_rst >= k) begin
      e_rgb = 0; e_hs = 0; e_vs = 0; e_disp = 0;
    end else begin
      sk     = hist[k];
      e_rgb  = exp_pixel(k);
      e_hs   = sk.hs;
      e_vs   = sk.vs;
      e_disp = sk.disp;
      if (sk.tag == 1 && sk.v == 0 && sk.h < 8)
        checkOutput("cell00_pixel", 32'(rgb), t2_pat[sk.h]);
      if (sk.tag == 5 && sk.v == 16 && sk.h == 24)
        checkOutput("cursor_blink", 32'(rgb), (sk.frame % 32 >= 16) ? FG : BG);
    end
    checkOutput("rgb", 32'(rgb), e_rgb);
    checkOutput("hsync_o", 32'(hsync_o), 32'(e_hs));
    checkOutput("vsync_o", 32'(vsync_o), 32'(e_vs));
    checkOutput("display_on_o", 32'(display_on_o), 32'(e_disp));
    checkOutput("ram_addr", 32'(ram_addr), exp_ram);
    checkOutput("rom_addr", 32'(rom_addr), exp_rom);
    if (s.tag == 1 && s.v == 17 && s.h == 248)
      checkOutput("ram_addr_r2c31", 32'(ram_addr), 32'h05F);
    if (n >= 2 && hist[n-2].tag == 1 && hist[n-2].v == 17 && hist[n-2].h == 248)
      checkOutput("rom_addr_line1", 32'(rom_addr[2:0]), 1);
  endtask

  task automatic applyStimulus(input int h, input int v, input bit disp,
                               input bit hs, input bit vs, input bit rst);
    sample_t s;
    @(negedge clk);
    if (hist.size() > 0) model_step(hist.size() - 1);
    hpos       = 9'(h);
    vpos       = 9'(v);
    display_on = disp;
    hsync      = hs;
    vsync      = vs;
    reset      = rst;
    s.h = h; s.v = v; s.disp = disp; s.hs = hs; s.vs = vs; s.rst = rst;
    s.cen = cursor_en; s.ccol = int'(cursor_col); s.crow = int'(cursor_row);
    s.fc = 0; s.tag = cur_tag; s.frame = cur_frame;
    hist.push_back(s);
  endtask

  task automatic scan_line(input int v, input int reset_h);
    for (int h = 0; h < 272; h++) begin
      if (rand_cursor && $urandom_range(0, 15) == 0) begin
        cursor_en  = 1'($urandom_range(0, 1));
        cursor_col = 5'($urandom_range(0, 31));
        cursor_row = ($urandom_range(0, 1) == 0) ? 5'(v / 8) : 5'($urandom_range(0, 29));
      end
      applyStimulus(h, v, (h < 256) && (v < 240), (h >= 260) && (h < 268), 1'b0, h == reset_h);
    end
  endtask

  task automatic vblank();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i, 245, 1'b0, (i % 8) < 2, (i >= 4) && (i < 10), 1'b0);
    end
    cur_frame++;
  endtask

  initial begin
    int start;
    reset = 1'b1; hpos = '0; vpos = '0; display_on = 1'b0; hsync = 1'b0; vsync = 1'b0;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    for (int i = 0; i < 1024; i++) ram_mem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
    ram_mem[0]        = 8'h41;
    rom_mem[8'h41*8]  = 8'hA5;

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

    cur_tag = 1;
    for (int v = 0; v < 24; v++) scan_line(v, -1);
    vblank();

    cur_tag = 2;
    rand_cursor = 1;
    start = $urandom_range(24, 200);
    for (int v = start; v < start + 8; v++) scan_line(v, -1);
    vblank();
    for (int v = 232; v < 242; v++) scan_line(v, -1);
    vblank();

    cur_tag = 6;
    rand_cursor = 0;
    cursor_en = 1'b0;
    scan_line(49, -1);
    scan_line(50, 100);
    scan_line(51, -1);
    vblank();

    cursor_en  = 1'b1;
    cursor_col = 5'd3;
    cursor_row = 5'd2;
    ram_mem[2*32 + 3] = 8'h80;
    for (int l = 0; l < 8; l++) rom_mem[8'h80*8 + l] = 8'h00;
    for (int i = 0; i < 2; i++) applyStimulus(0, 250, 1'b0, 1'b0, 1'b0, 1'b1);
    cur_tag   = 5;
    cur_frame = 0;
    for (int f = 0; f < 34; f++) begin
      scan_line(16, -1);
      vblank();
    end

    cur_tag = 0;
    for (int i = 0; i < 10; i++) applyStimulus(0, 250, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
